xcr_ctrl_regfile: RTL



---
 rtl/xcr_ctrl_if.sv | 36 +++
 rtl/xcr_ctrl_regfile.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/xcr_ctrl_if.sv
// Host-side addressed stream pair for the xcr_ctrl register bank.
// One write stream and one read stream that share a single word address.
interface xcr_ctrl_if;
  logic        user_w_xcr_ctrl_wren;
  logic [31:0] user_w_xcr_ctrl_data;
  logic        user_w_xcr_ctrl_full;
  logic        user_r_xcr_ctrl_rden;
  logic [31:0] user_r_xcr_ctrl_data;
  logic        user_r_xcr_ctrl_empty;
  logic        user_r_xcr_ctrl_eof;
  logic [4:0]  user_xcr_ctrl_addr;

  // Host side: issues strobes, data and address.
  modport master (
    output user_w_xcr_ctrl_wren,
    output user_w_xcr_ctrl_data,
    output user_r_xcr_ctrl_rden,
    output user_xcr_ctrl_addr,
    input  user_w_xcr_ctrl_full,
    input  user_r_xcr_ctrl_data,
    input  user_r_xcr_ctrl_empty,
    input  user_r_xcr_ctrl_eof
  );

  // Register bank side: consumes writes, answers reads.
  modport slave (
    input  user_w_xcr_ctrl_wren,
    input  user_w_xcr_ctrl_data,
    input  user_r_xcr_ctrl_rden,
    input  user_xcr_ctrl_addr,
    output user_w_xcr_ctrl_full,
    output user_r_xcr_ctrl_data,
    output user_r_xcr_ctrl_empty,
    output user_r_xcr_ctrl_eof
  );
endinterface

// File: rtl/xcr_ctrl_regfile.sv
// Register bank and run controller for the hotspot compute kernel.
// Holds run parameters, issues start / soft-reset to the kernel and reports
// status, cycle count and run count back to the host over xcr_ctrl.
module xcr_ctrl_regfile #(
  parameter int          NUM_PARAMS      = 12,
  parameter int          SOFT_RST_CYCLES = 16,
  parameter logic [31:0] VERSION         = 32'h48530001
) (
  input  logic                    bus_clk,
  input  logic                    trn_reset_n,
  xcr_ctrl_if.slave               bus,
  output logic                    kernel_start,
  output logic                    kernel_soft_rst,
  input  logic                    kernel_done,
  output logic [32*NUM_PARAMS-1:0] param_out
);

  localparam logic [4:0]  ADDR_CTRL    = 5'd0;
  localparam logic [4:0]  ADDR_STATUS  = 5'd1;
  localparam logic [4:0]  ADDR_CYCLES  = 5'd2;
  localparam logic [4:0]  ADDR_RUNS    = 5'd3;
  localparam logic [4:0]  ADDR_PARAM   = 5'd4;
  localparam logic [4:0]  ADDR_VERSION = 5'd31;
  localparam logic [31:0] SRST_LOAD    = 32'(SOFT_RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SRST = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [31:0] srst_cnt;
  logic [31:0] cycles;
  logic [31:0] runs;
  logic        done;
  logic        start_dropped;
  logic [31:0] params [NUM_PARAMS];
  logic [31:0] rd_mux;
  logic [31:0] rd_data;

  logic        wren;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ctrl_wr;
  logic        status_wr;
  logic        start_req;
  logic        srst_req;
  logic        start_fire;
  logic        drop_fire;
  logic        done_fire;

  // Saturating increment: the cycle counter parks at all-ones on very long runs.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign wren      = bus.user_w_xcr_ctrl_wren;
  assign addr      = bus.user_xcr_ctrl_addr;
  assign wdata     = bus.user_w_xcr_ctrl_data;
  assign ctrl_wr   = wren && (addr == ADDR_CTRL);
  assign status_wr = wren && (addr == ADDR_STATUS);
  // SOFT_RST wins over START when both bits are written together.
  assign srst_req  = ctrl_wr && wdata[1];
  assign start_req = ctrl_wr && wdata[0] && !wdata[1];

  // The stream is never back-pressured and never runs dry or ends.
  assign bus.user_w_xcr_ctrl_full  = 1'b0;
  assign bus.user_r_xcr_ctrl_empty = 1'b0;
  assign bus.user_r_xcr_ctrl_eof   = 1'b0;
  assign bus.user_r_xcr_ctrl_data  = rd_data;

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_param_out
    assign param_out[32*g +: 32] = params[g];
  end

  // FSM state register plus the soft-reset countdown.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      state    <= IDLE;
      srst_cnt <= '0;
    end else begin
      state <= next_state;
      if (srst_req)
        srst_cnt <= SRST_LOAD;
      else if (state == SRST && srst_cnt != 32'd0)
        srst_cnt <= srst_cnt - 32'd1;
    end
  end

  // Next-state decode and the single-cycle events that drive the registers.
  always_comb begin
    next_state = state;
    start_fire = 1'b0;
    drop_fire  = 1'b0;
    done_fire  = 1'b0;
    if (srst_req) begin
      next_state = SRST;
    end else begin
      unique case (state)
        IDLE: begin
          // kernel_done is meaningless here, including the accepting cycle.
          if (start_req) begin
            next_state = RUN;
            start_fire = 1'b1;
          end
        end
        RUN: begin
          if (start_req)
            drop_fire = 1'b1;
          if (kernel_done) begin
            next_state = IDLE;
            done_fire  = 1'b1;
          end
        end
        SRST: begin
          // START is silently ignored while the kernel is held in reset.
          if (srst_cnt == 32'd0)
            next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Kernel control outputs are registered so they start on the next cycle.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      kernel_start    <= 1'b0;
      kernel_soft_rst <= 1'b0;
    end else begin
      kernel_start    <= start_fire;
      kernel_soft_rst <= (next_state == SRST);
    end
  end

  // Sticky status bits; a coincident set beats the host's write-1-to-clear.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      done          <= 1'b0;
      start_dropped <= 1'b0;
    end else begin
      if (srst_req)
        done <= 1'b0;
      else if (done_fire)
        done <= 1'b1;
      else if (status_wr && wdata[1])
        done <= 1'b0;

      if (drop_fire)
        start_dropped <= 1'b1;
      else if (status_wr && wdata[3])
        start_dropped <= 1'b0;
    end
  end

  // Run statistics: cycles restarts on each accepted START, counts every RUN
  // cycle including the one that sees kernel_done, then holds.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      cycles <= '0;
      runs   <= '0;
    end else begin
      if (start_fire)
        cycles <= '0;
      else if (state == RUN && !srst_req)
        cycles <= sat_inc(cycles);
      if (done_fire)
        runs <= runs + 32'd1;
    end
  end

  // Parameter words; soft reset leaves them alone, hard reset clears them.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      for (int i = 0; i < NUM_PARAMS; i++)
        params[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PARAMS; i++)
        if (wren && addr == ADDR_PARAM + 5'(i))
          params[i] <= wdata;
    end
  end

  // Read mux over the current register contents (pre-write on a collision).
  always_comb begin
    rd_mux = '0;
    unique case (addr)
      ADDR_STATUS:  rd_mux = {28'd0, start_dropped, (state == SRST), done, (state == RUN)};
      ADDR_CYCLES:  rd_mux = cycles;
      ADDR_RUNS:    rd_mux = runs;
      ADDR_VERSION: rd_mux = VERSION;
      default: begin
        for (int i = 0; i < NUM_PARAMS; i++)
          if (addr == ADDR_PARAM + 5'(i))
            rd_mux = params[i];
      end
    endcase
  end

  // Registered read port: one-cycle latency, holds while rden is low.
  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n)
      rd_data <= '0;
    else if (bus.user_r_xcr_ctrl_rden)
      rd_data <= rd_mux;
  end

endmodule
